// File: rtl/time_of_day_ctrl_if.sv
// Tick, button and display-side signals of the time-of-day controller.
// The master side drives ticks/buttons and reads the display fields.
interface time_of_day_ctrl_if;
    logic       tick_s;
    logic       tick_hs;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blank_h;
    logic       blank_m;
    logic       setting;
    logic       day_wrap;

    modport master (
        output tick_s, tick_hs, btn_mode, btn_inc,
        input  hours, minutes, seconds, blank_h, blank_m, setting, day_wrap
    );

    modport slave (
        input  tick_s, tick_hs, btn_mode, btn_inc,
        output hours, minutes, seconds, blank_h, blank_m, setting, day_wrap
    );
endinterface

// File: rtl/time_of_day_ctrl.sv
// 24h time-of-day sequencer with a RUN/SET_H/SET_M button-driven editor.
// Set fields blink at 1 Hz from the 2 Hz tick; every output is a flop.
module time_of_day_ctrl #(
    parameter int HOUR_WRAP   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                rst_n,
    time_of_day_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_e;

    localparam logic [4:0] HOUR_MAX = 5'(HOUR_WRAP - 1);

    state_e                 state_q, state_d;
    logic [4:0]             hours_q, hours_d;
    logic [5:0]             minutes_q, minutes_d;
    logic [5:0]             seconds_q, seconds_d;
    logic                   phase_q, phase_d;
    logic                   blank_h_q, blank_h_d;
    logic                   blank_m_q, blank_m_d;
    logic                   setting_q, setting_d;
    logic                   day_wrap_q, day_wrap_d;
    logic [SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;
    logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
    logic                   mode_prev_q, mode_prev_d;
    logic                   inc_prev_q, inc_prev_d;
    logic                   mode_press_s;
    logic                   inc_press_s;

    // Button synchronizers and rising-edge detectors.
    always_comb begin
        mode_sync_d  = {mode_sync_q[SYNC_STAGES-2:0], bus.btn_mode};
        inc_sync_d   = {inc_sync_q[SYNC_STAGES-2:0], bus.btn_inc};
        mode_prev_d  = mode_sync_q[SYNC_STAGES-1];
        inc_prev_d   = inc_sync_q[SYNC_STAGES-1];
        mode_press_s = mode_sync_q[SYNC_STAGES-1] & ~mode_prev_q;
        inc_press_s  = inc_sync_q[SYNC_STAGES-1] & ~inc_prev_q;
    end

    // Next-state, time-field and blink computation.
    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        day_wrap_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.tick_s) begin
                    if (seconds_q == 6'd59) begin
                        seconds_d = 6'd0;
                        if (minutes_q == 6'd59) begin
                            minutes_d = 6'd0;
                            if (hours_q == HOUR_MAX) begin
                                hours_d    = 5'd0;
                                day_wrap_d = 1'b1;
                            end else begin
                                hours_d = hours_q + 5'd1;
                            end
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end else begin
                    seconds_d = seconds_q;
                end
                if (mode_press_s) begin
                    state_d = ST_SET_H;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_H: begin
                if (mode_press_s) begin
                    state_d = ST_SET_M;
                end else if (inc_press_s) begin
                    hours_d = (hours_q == HOUR_MAX) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    state_d = ST_SET_H;
                end
            end
            ST_SET_M: begin
                if (mode_press_s) begin
                    // Leaving the editor restarts the minute cleanly.
                    state_d   = ST_RUN;
                    seconds_d = 6'd0;
                end else if (inc_press_s) begin
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                end else begin
                    state_d = ST_SET_M;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (state_d != state_q) begin
            phase_d = 1'b0;
        end else if ((state_q != ST_RUN) && bus.tick_hs) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end

        blank_h_d = (state_d == ST_SET_H) & phase_d;
        blank_m_d = (state_d == ST_SET_M) & phase_d;
        setting_d = (state_d != ST_RUN);
    end

    // State, time, blink and synchronizer registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            hours_q     <= 5'd0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            phase_q     <= 1'b0;
            blank_h_q   <= 1'b0;
            blank_m_q   <= 1'b0;
            setting_q   <= 1'b0;
            day_wrap_q  <= 1'b0;
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            phase_q     <= phase_d;
            blank_h_q   <= blank_h_d;
            blank_m_q   <= blank_m_d;
            setting_q   <= setting_d;
            day_wrap_q  <= day_wrap_d;
            mode_sync_q <= mode_sync_d;
            inc_sync_q  <= inc_sync_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.blank_h  = blank_h_q;
    assign bus.blank_m  = blank_m_q;
    assign bus.setting  = setting_q;
    assign bus.day_wrap = day_wrap_q;
endmodule

// File: tb/tb_time_of_day_ctrl.sv
// Bench for time_of_day_ctrl: directed scenarios then random ops, checked
// against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_time_of_day_ctrl;
    localparam int HW = 24;

    logic clk_in;
    logic rst_n;
    time_of_day_ctrl_if bus_if();

    time_of_day_ctrl #(.HOUR_WRAP(HW), .SYNC_STAGES(2)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int dw_count = 0;
    int exp_dw   = 0;

    // Reference model: time as seconds of day, mode 0=RUN 1=SET_H 2=SET_M.
    int  m_tod   = 0;
    int  m_mode  = 0;
    bit  m_phase = 1'b0;

    always @(negedge clk_in) if (bus_if.day_wrap === 1'b1) dw_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hours"},   32'(bus_if.hours),   32'(m_tod / 3600));
        check({tag, ".minutes"}, 32'(bus_if.minutes), 32'((m_tod / 60) % 60));
        check({tag, ".seconds"}, 32'(bus_if.seconds), 32'(m_tod % 60));
        check({tag, ".setting"}, 32'(bus_if.setting), 32'(m_mode != 0));
        check({tag, ".blank_h"}, 32'(bus_if.blank_h), 32'((m_mode == 1) && m_phase));
        check({tag, ".blank_m"}, 32'(bus_if.blank_m), 32'((m_mode == 2) && m_phase));
    endtask

    task automatic check_dw(input string tag);
        #1;
        check(tag, 32'(dw_count), 32'(exp_dw));
    endtask

    task automatic model_tick();
        if (m_mode == 0) begin
            m_tod = (m_tod + 1) % (HW * 3600);
            if (m_tod == 0) exp_dw++;
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_mode = 0; m_phase = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            bus_if.tick_s = 1'b1;
            @(negedge clk_in);
            bus_if.tick_s = 1'b0;
            model_tick();
        end
    endtask

    task automatic tick_hs_pulse();
        bus_if.tick_hs = 1'b1;
        @(negedge clk_in);
        bus_if.tick_hs = 1'b0;
        if (m_mode != 0) m_phase = ~m_phase;
    endtask

    // Button press whose effect lands on the edge where tick_s is optionally pulsed.
    task automatic press(input bit m, input bit i, input bit t);
        int h, mi, s;
        bus_if.btn_mode = m;
        bus_if.btn_inc  = i;
        @(negedge clk_in);
        @(negedge clk_in);
        bus_if.tick_s = t;
        @(negedge clk_in);
        bus_if.tick_s   = 1'b0;
        bus_if.btn_mode = 1'b0;
        bus_if.btn_inc  = 1'b0;
        if (t) model_tick();
        h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
        if (m) begin
            if (m_mode == 2) s = 0;
            m_mode  = (m_mode + 1) % 3;
            m_phase = 1'b0;
        end else if (i) begin
            if (m_mode == 1) h = (h + 1) % HW;
            if (m_mode == 2) mi = (mi + 1) % 60;
        end
        m_tod = h * 3600 + mi * 60 + s;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic set_time(input int h, input int mi);
        press(1'b1, 1'b0, 1'b0);
        repeat ((h - m_tod / 3600 + HW) % HW) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat ((mi - (m_tod / 60) % 60 + 60) % 60) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        bus_if.tick_s = 1'b0; bus_if.tick_hs = 1'b0;
        bus_if.btn_mode = 1'b0; bus_if.btn_inc = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_all("reset");
        check("reset.day_wrap", 32'(bus_if.day_wrap), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_in);

        // 1: 3661 ticks -> 01:01:01 with no day wrap
        tick_n(3661);
        check_all("t1");
        check_dw("t1.no_wrap");

        // 2: 23:59:58 -> 23:59:59 -> 00:00:00 with a single wrap pulse
        set_time(23, 59);
        tick_n(58);
        check_all("t2.58");
        tick_n(1);
        check_all("t2.59");
        check_dw("t2.pre_wrap");
        tick_n(1);
        check_all("t2.wrap");
        check("t2.dw_high", 32'(bus_if.day_wrap), 32'd1);
        @(negedge clk_in);
        check("t2.dw_low", 32'(bus_if.day_wrap), 32'd0);
        check_dw("t2.one_wrap");

        // 3: SET_H, 25 increments wrap to 01, ticks frozen
        press(1'b1, 1'b0, 1'b0);
        check_all("t3.enter");
        repeat (25) press(1'b0, 1'b1, 1'b0);
        check_all("t3.inc25");
        tick_n(5);
        check_all("t3.frozen");

        // 4: SET_M 58 -> 59, 00, 01, then back to RUN with seconds cleared
        press(1'b1, 1'b0, 1'b0);
        repeat (58) press(1'b0, 1'b1, 1'b0);
        check_all("t4.m58");
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1, 1'b0);
            check_all($sformatf("t4.inc%0d", k));
        end
        tick_n(3);
        press(1'b1, 1'b0, 1'b0);
        check_all("t4.run");

        // tick_s and mode press on the same edge in RUN
        tick_n(7);
        press(1'b1, 1'b0, 1'b1);
        check_all("sim.tick_mode");

        // 5: blink in SET_H and held INC gives one increment
        check_all("t5.blink0");
        for (int k = 0; k < 4; k++) begin
            tick_hs_pulse();
            check_all($sformatf("t5.blink%0d", k + 1));
        end
        bus_if.btn_inc = 1'b1;
        repeat (1000) @(negedge clk_in);
        bus_if.btn_inc = 1'b0;
        repeat (3) @(negedge clk_in);
        m_tod = ((m_tod / 3600 + 1) % HW) * 3600 + m_tod % 3600;
        check_all("t5.held_inc");
        press(1'b1, 1'b0, 1'b0);
        tick_hs_pulse();
        check_all("t5.blank_m");
        press(1'b1, 1'b0, 1'b0);
        check_all("t5.run");

        // 6: mode+inc together in RUN, then reset mid-SET_M
        press(1'b1, 1'b1, 1'b0);
        check_all("t6.mode_wins");
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check_all("t6.set_m");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async_rst");
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        check_all("t6.after_rst");

        // Random operation mix against the model
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 4))
                0: tick_n($urandom_range(1, 90));
                1: tick_hs_pulse();
                2: press(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                3: press(1'b0, 1'b1, 1'b0);
                default: press(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            endcase
            check_all($sformatf("rnd%0d", it));
        end
        check_dw("rnd.wraps");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
